present_cbc_ctrl: RTL

PRESENT_CBC_CTRL -- requirements
Module: present_cbc_ctrl

---
 rtl/present_cbc_ctrl_pkg.sv | 20 ++
 rtl/present_cbc_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/present_cbc_ctrl_pkg.sv
// PRESENT-80 CBC controller shared definitions.
// Widths, mode encodings and the FSM state type.
package present_cbc_ctrl_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_RST  = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_READY    = 3'd3,
    ST_COMPUTE  = 3'd4,
    ST_OUTPUT   = 3'd5
  } state_e;

endpackage

// File: rtl/present_cbc_ctrl.sv
// PRESENT-80 CBC/ECB block controller sitting beside a PRESENT core.
// Ports:
//   clk, rst (async, active-low)
//   key_load/key_i/iv_i/enc_dec_i : key, IV and mode load
//   key_ready_o                   : round keys valid, block usable
//   in_valid/in_ready/in_data     : input block handshake
//   out_valid/out_ready/out_data  : result block handshake
//   core_rst/core_key/core_enc_dec/core_block : drive to core
//   core_end/core_result          : status and result from core
module present_cbc_ctrl
  import present_cbc_ctrl_pkg::*;
#(
  parameter logic CBC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_i,
  input  logic [BLK_W-1:0] iv_i,
  input  logic             enc_dec_i,
  output logic             key_ready_o,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             core_rst,
  output logic [KEY_W-1:0] core_key,
  output logic             core_enc_dec,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_end,
  input  logic [BLK_W-1:0] core_result
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             mode_q, mode_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [BLK_W-1:0] out_q, out_d;

  logic is_enc;
  assign is_enc = (mode_q == ENC);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    block_d = block_q;
    chain_d = chain_q;
    out_d   = out_q;
    // A key load wins from every state and restarts expansion.
    if (key_load) begin
      state_d = ST_KEY_RST;
      key_d   = key_i;
      mode_d  = enc_dec_i;
      chain_d = CBC_EN ? iv_i : '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_KEY_RST: begin
          state_d = ST_KEY_WAIT;
        end
        ST_KEY_WAIT: begin
          if (core_end) state_d = ST_READY;
        end
        ST_READY: begin
          // Losing core_end means the round keys are gone.
          if (!core_end) begin
            state_d = ST_KEY_RST;
          end else if (in_valid) begin
            block_d = is_enc ? (in_data ^ chain_q)
                             : in_data;
            state_d = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (!core_end) begin
            state_d = ST_KEY_RST;
          end else begin
            out_d = is_enc ? core_result
                           : (core_result ^ chain_q);
            // Decrypt chains on the ciphertext, which is
            // exactly what sits in the block register.
            if (CBC_EN) begin
              chain_d = is_enc ? core_result : block_q;
            end else begin
              chain_d = '0;
            end
            state_d = ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (!core_end) begin
            state_d = ST_KEY_RST;
          end else if (out_ready) begin
            state_d = ST_READY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      mode_q  <= ENC;
      block_q <= '0;
      chain_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      block_q <= block_d;
      chain_q <= chain_d;
      out_q   <= out_d;
    end
  end

  // The core is held in reset while idle and for the
  // single KEY_RST cycle that precedes each expansion.
  assign core_rst = (state_q == ST_IDLE)
                 || (state_q == ST_KEY_RST);

  assign in_ready = (state_q == ST_READY) && !key_load;

  assign out_valid = (state_q == ST_OUTPUT);

  assign key_ready_o = (state_q == ST_READY)
                    || (state_q == ST_COMPUTE)
                    || (state_q == ST_OUTPUT);

  assign core_key     = key_q;
  assign core_enc_dec = mode_q;
  assign core_block   = block_q;
  assign out_data     = out_q;

endmodule
